// File: rtl/fk_hop_sched_if.sv
// Signal bundle between the hop scheduler, slot timing, hop kernel and PLL.
// The slave side is the scheduler; the master side drives its inputs.
interface fk_hop_sched_if;
  logic        hop_en;
  logic        m_tslot_p;
  logic [11:0] regi_fkset_lead;
  logic        fk_ack;
  logic [6:0]  fk_chan;
  logic        pll_lock;
  logic [11:0] slot_cnt;
  logic        fkset_p;
  logic        fk_req;
  logic [6:0]  pll_chan;
  logic        pll_load_p;
  logic        pll_ready;
  logic        fk_err;
  logic        fk_ovr;

  modport master (
    output hop_en, m_tslot_p, regi_fkset_lead, fk_ack, fk_chan, pll_lock,
    input  slot_cnt, fkset_p, fk_req, pll_chan, pll_load_p, pll_ready, fk_err, fk_ovr
  );

  modport slave (
    input  hop_en, m_tslot_p, regi_fkset_lead, fk_ack, fk_chan, pll_lock,
    output slot_cnt, fkset_p, fk_req, pll_chan, pll_load_p, pll_ready, fk_err, fk_ovr
  );
endinterface

// File: rtl/fk_hop_sched.sv
// Per-slot hop scheduler: slot position counter, fkset_p lead strobe, and the
// request / load / settle sequence that retunes the PLL before each slot.
module fk_hop_sched #(
  parameter int SLOT_CYC   = 3750,
  parameter int ACK_TO     = 64,
  parameter int PLL_SETTLE = 720,
  parameter int MAX_CHAN   = 78
) (
  input  logic          clk_6M,
  input  logic          rstz,
  fk_hop_sched_if.slave hs
);
  localparam int AW = $clog2(ACK_TO + 1);
  localparam int SW = $clog2(PLL_SETTLE + 1);
  localparam logic [11:0]   SLOT_LAST   = 12'(SLOT_CYC - 1);
  localparam logic [AW-1:0] ACK_LAST    = AW'(ACK_TO - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(PLL_SETTLE - 1);
  localparam logic [6:0]    CHAN_MAX    = 7'(MAX_CHAN);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, SETTLE, READY} state_t;

  state_t        state;
  logic [11:0]   slot_cnt;
  logic [11:0]   lead_eff;
  logic [11:0]   match_cnt;
  logic          fkset_p;
  logic          fk_req;
  logic [6:0]    pll_chan;
  logic          pll_load_p;
  logic          pll_ready;
  logic          fk_err;
  logic          fk_ovr;
  logic [AW-1:0] ack_cnt;
  logic [SW-1:0] settle_cnt;

  // Lead is clamped to [1, SLOT_CYC-1] so the match point always lies inside the slot.
  always_comb begin
    lead_eff = hs.regi_fkset_lead;
    if (hs.regi_fkset_lead == 12'd0)
      lead_eff = 12'd1;
    else if (hs.regi_fkset_lead > SLOT_LAST)
      lead_eff = SLOT_LAST;
  end

  assign match_cnt = 12'(SLOT_CYC) - lead_eff;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)
      slot_cnt <= '0;
    else if (hs.m_tslot_p || slot_cnt == SLOT_LAST)
      slot_cnt <= '0;
    else
      slot_cnt <= slot_cnt + 12'd1;
  end

  // A slot boundary landing on the match cycle restarts the slot, so no strobe.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)
      fkset_p <= 1'b0;
    else
      fkset_p <= hs.hop_en && !hs.m_tslot_p && (slot_cnt == match_cnt);
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state      <= IDLE;
      fk_req     <= 1'b0;
      pll_chan   <= '0;
      pll_load_p <= 1'b0;
      pll_ready  <= 1'b0;
      fk_err     <= 1'b0;
      fk_ovr     <= 1'b0;
      ack_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      pll_load_p <= 1'b0;
      fk_err     <= 1'b0;
      fk_ovr     <= 1'b0;
      if (!hs.hop_en) begin
        state     <= IDLE;
        fk_req    <= 1'b0;
        pll_ready <= 1'b0;
      end else begin
        // A new strobe while a sequence is in flight is dropped and flagged.
        fk_ovr <= fkset_p && (state inside {REQ, LOAD, SETTLE});
        case (state)
          IDLE, READY: begin
            if (fkset_p) begin
              state     <= REQ;
              fk_req    <= 1'b1;
              pll_ready <= 1'b0;
              ack_cnt   <= '0;
            end
          end
          REQ: begin
            if (hs.fk_ack) begin
              fk_req <= 1'b0;
              if (hs.fk_chan <= CHAN_MAX) begin
                pll_chan   <= hs.fk_chan;
                pll_load_p <= 1'b1;
                state      <= LOAD;
              end else begin
                fk_err <= 1'b1;
                state  <= IDLE;
              end
            end else if (ack_cnt == ACK_LAST) begin
              fk_req <= 1'b0;
              fk_err <= 1'b1;
              state  <= IDLE;
            end else begin
              ack_cnt <= ack_cnt + 1'b1;
            end
          end
          LOAD: begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (hs.pll_lock || settle_cnt == SETTLE_LAST) begin
              pll_ready <= 1'b1;
              state     <= READY;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign hs.slot_cnt   = slot_cnt;
  assign hs.fkset_p    = fkset_p;
  assign hs.fk_req     = fk_req;
  assign hs.pll_chan   = pll_chan;
  assign hs.pll_load_p = pll_load_p;
  assign hs.pll_ready  = pll_ready;
  assign hs.fk_err     = fk_err;
  assign hs.fk_ovr     = fk_ovr;
endmodule

// File: tb/tb_fk_hop_sched.sv
// Directed bench for fk_hop_sched: lead timing, hop sequence, errors, overrun,
// disable and asynchronous reset, with hand-computed cycle offsets.
module tb_fk_hop_sched;
  logic clk_6M = 1'b0;
  logic rstz;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  fk_hop_sched_if ifc ();

  fk_hop_sched dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .hs     (ifc)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic tick();
    @(posedge clk_6M);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fkset(input int lim);
    int k;
    k = 0;
    while (ifc.fkset_p !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    n_chk++;
    if (ifc.fkset_p !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_fkset: fkset_p=%0b after %0d cycles, required 1", ifc.fkset_p, k);
    end
  endtask

  // Force IDLE, set lead 3700 and restart the slot: fkset_p arrives when slot_cnt==51.
  task automatic resync();
    ifc.hop_en   = 1'b0;
    ifc.fk_ack   = 1'b0;
    ifc.pll_lock = 1'b0;
    ticks(2);
    ifc.regi_fkset_lead = 12'd3700;
    ifc.hop_en    = 1'b1;
    ifc.m_tslot_p = 1'b1;
    tick();
    ifc.m_tslot_p = 1'b0;
  endtask

  task automatic test_reset();
    ifc.hop_en = 1'b0; ifc.m_tslot_p = 1'b0; ifc.regi_fkset_lead = 12'd0;
    ifc.fk_ack = 1'b0; ifc.fk_chan = 7'd0; ifc.pll_lock = 1'b0;
    rstz = 1'b1;
    #2 rstz = 1'b0;
    #1;
    n_chk++; if (ifc.slot_cnt !== 12'd0) begin n_fail++; $display("FAIL rst_slot_cnt: got %0d want 0", ifc.slot_cnt); end
    n_chk++; if (ifc.fkset_p !== 1'b0) begin n_fail++; $display("FAIL rst_fkset_p: got %0b want 0", ifc.fkset_p); end
    n_chk++; if (ifc.fk_req !== 1'b0) begin n_fail++; $display("FAIL rst_fk_req: got %0b want 0", ifc.fk_req); end
    n_chk++; if (ifc.pll_chan !== 7'd0) begin n_fail++; $display("FAIL rst_pll_chan: got %0d want 0", ifc.pll_chan); end
    n_chk++; if (ifc.pll_load_p !== 1'b0) begin n_fail++; $display("FAIL rst_pll_load_p: got %0b want 0", ifc.pll_load_p); end
    n_chk++; if (ifc.pll_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pll_ready: got %0b want 0", ifc.pll_ready); end
    n_chk++; if (ifc.fk_err !== 1'b0) begin n_fail++; $display("FAIL rst_fk_err: got %0b want 0", ifc.fk_err); end
    n_chk++; if (ifc.fk_ovr !== 1'b0) begin n_fail++; $display("FAIL rst_fk_ovr: got %0b want 0", ifc.fk_ovr); end
    ticks(2);
    rstz = 1'b1;
    tick();
    n_chk++; if (ifc.slot_cnt !== 12'd1) begin n_fail++; $display("FAIL slot_cnt_runs_disabled: got %0d want 1", ifc.slot_cnt); end
  endtask

  task automatic observe_slot(input logic [11:0] lead, input bit use_tslot, input int exp_at, input string nm);
    int n, at, k;
    logic [11:0] prev;
    n = 0; at = -1; k = 0;
    ifc.regi_fkset_lead = lead;
    while (ifc.slot_cnt !== 12'd0 && k < 4000) begin tick(); k++; end
    for (int i = 0; i < 3750; i++) begin
      prev = ifc.slot_cnt;
      ifc.m_tslot_p = use_tslot && (ifc.slot_cnt == 12'd3749);
      tick();
      if (ifc.fkset_p === 1'b1) begin n++; at = int'(prev); end
    end
    ifc.m_tslot_p = 1'b0;
    n_chk++; if (n != 1) begin n_fail++; $display("FAIL %s_count: got %0d strobes want 1", nm, n); end
    n_chk++; if (at != exp_at) begin n_fail++; $display("FAIL %s_pos: strobe after slot_cnt %0d want %0d", nm, at, exp_at); end
  endtask

  task automatic test_lead();
    int k;
    ifc.hop_en = 1'b1;
    ifc.m_tslot_p = 1'b1;
    tick();
    ifc.m_tslot_p = 1'b0;
    observe_slot(12'd900, 1'b1, 2850, "lead900");
    observe_slot(12'd0, 1'b0, 3749, "lead0");
    observe_slot(12'd4000, 1'b1, 1, "lead4000");
    // slot boundary landing on the match cycle suppresses the strobe
    ifc.regi_fkset_lead = 12'd900;
    k = 0;
    while (ifc.slot_cnt !== 12'd2850 && k < 4000) begin tick(); k++; end
    ifc.m_tslot_p = 1'b1;
    tick();
    ifc.m_tslot_p = 1'b0;
    n_chk++; if (ifc.fkset_p !== 1'b0) begin n_fail++; $display("FAIL tslot_match_fkset: got %0b want 0", ifc.fkset_p); end
    n_chk++; if (ifc.slot_cnt !== 12'd0) begin n_fail++; $display("FAIL tslot_match_cnt: got %0d want 0", ifc.slot_cnt); end
  endtask

  task automatic test_nominal();
    int t_load, loads;
    resync();
    wait_fkset(100);
    n_chk++; if (ifc.slot_cnt !== 12'd51) begin n_fail++; $display("FAIL fkset_slot_pos: got %0d want 51", ifc.slot_cnt); end
    tick();
    n_chk++; if (ifc.fk_req !== 1'b1) begin n_fail++; $display("FAIL fkset_to_req: got %0b want 1", ifc.fk_req); end
    ticks(5);
    n_chk++; if (ifc.fk_req !== 1'b1) begin n_fail++; $display("FAIL req_held: got %0b want 1", ifc.fk_req); end
    ifc.fk_ack = 1'b1; ifc.fk_chan = 7'd37;
    tick();
    ifc.fk_ack = 1'b0;
    t_load = cyc; loads = 0;
    n_chk++; if (ifc.pll_load_p !== 1'b1) begin n_fail++; $display("FAIL ack_to_load: got %0b want 1", ifc.pll_load_p); end
    n_chk++; if (ifc.fk_req !== 1'b0) begin n_fail++; $display("FAIL req_drop: got %0b want 0", ifc.fk_req); end
    n_chk++; if (ifc.pll_chan !== 7'd37) begin n_fail++; $display("FAIL nominal_chan: got %0d want 37", ifc.pll_chan); end
    if (ifc.pll_load_p === 1'b1) loads++;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifc.pll_load_p === 1'b1) loads++;
    end
    n_chk++; if (ifc.pll_ready !== 1'b0) begin n_fail++; $display("FAIL ready_early: got %0b want 0 at load+%0d", ifc.pll_ready, cyc - t_load); end
    ifc.pll_lock = 1'b1;
    tick();
    n_chk++; if (ifc.pll_ready !== 1'b1) begin n_fail++; $display("FAIL ready_at_load101: got %0b want 1 at load+%0d", ifc.pll_ready, cyc - t_load); end
    n_chk++; if (loads != 1) begin n_fail++; $display("FAIL load_pulse_count: got %0d want 1", loads); end
  endtask

  task automatic test_bad_chan();
    wait_fkset(4000);
    n_chk++; if (ifc.pll_ready !== 1'b1) begin n_fail++; $display("FAIL ready_held: got %0b want 1", ifc.pll_ready); end
    tick();
    n_chk++; if (ifc.pll_ready !== 1'b0) begin n_fail++; $display("FAIL ready_clr_req: got %0b want 0", ifc.pll_ready); end
    ifc.fk_ack = 1'b1; ifc.fk_chan = 7'd79;
    tick();
    ifc.fk_ack = 1'b0; ifc.pll_lock = 1'b0;
    n_chk++; if (ifc.fk_err !== 1'b1) begin n_fail++; $display("FAIL badchan_err: got %0b want 1", ifc.fk_err); end
    n_chk++; if (ifc.pll_chan !== 7'd37) begin n_fail++; $display("FAIL badchan_keep: got %0d want 37", ifc.pll_chan); end
    tick();
    n_chk++; if (ifc.fk_err !== 1'b0) begin n_fail++; $display("FAIL badchan_err_width: got %0b want 0", ifc.fk_err); end
    ticks(3);
    n_chk++; if ({ifc.fk_req, ifc.pll_load_p, ifc.pll_ready} !== 3'b000) begin n_fail++; $display("FAIL badchan_idle: req/load/ready got %03b want 000", {ifc.fk_req, ifc.pll_load_p, ifc.pll_ready}); end
  endtask

  task automatic test_ack_timeout();
    int k;
    resync();
    wait_fkset(100);
    tick();
    k = 0;
    while (ifc.fk_err !== 1'b1 && k < 100) begin tick(); k++; end
    n_chk++; if (k != 64) begin n_fail++; $display("FAIL ack_timeout: fk_err at REQ+%0d want REQ+64", k); end
    n_chk++; if (ifc.fk_req !== 1'b0) begin n_fail++; $display("FAIL timeout_req: got %0b want 0", ifc.fk_req); end
  endtask

  task automatic test_settle_timeout();
    int k;
    resync();
    wait_fkset(100);
    tick();
    ticks(63);
    n_chk++; if (ifc.fk_req !== 1'b1) begin n_fail++; $display("FAIL req_last_cycle: got %0b want 1", ifc.fk_req); end
    ifc.fk_ack = 1'b1; ifc.fk_chan = 7'd78;
    tick();
    ifc.fk_ack = 1'b0;
    n_chk++; if (ifc.pll_load_p !== 1'b1 || ifc.fk_err !== 1'b0) begin n_fail++; $display("FAIL ack_on_timeout: load=%0b err=%0b want load=1 err=0", ifc.pll_load_p, ifc.fk_err); end
    n_chk++; if (ifc.pll_chan !== 7'd78) begin n_fail++; $display("FAIL chan78: got %0d want 78", ifc.pll_chan); end
    ifc.pll_lock = 1'b1;
    tick();
    ifc.pll_lock = 1'b0;
    k = 1;
    while (ifc.pll_ready !== 1'b1 && k < 800) begin tick(); k++; end
    n_chk++; if (k != 721) begin n_fail++; $display("FAIL settle_timeout: ready at load+%0d want load+721", k); end
  endtask

  task automatic test_overrun();
    int t_load, k;
    resync();
    wait_fkset(100);
    tick();
    ifc.fk_ack = 1'b1; ifc.fk_chan = 7'd20;
    tick();
    ifc.fk_ack = 1'b0;
    t_load = cyc;
    ticks(10);
    ifc.m_tslot_p = 1'b1;
    tick();
    ifc.m_tslot_p = 1'b0;
    wait_fkset(100);
    tick();
    n_chk++; if (ifc.fk_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %0b want 1", ifc.fk_ovr); end
    n_chk++; if (ifc.fk_req !== 1'b0) begin n_fail++; $display("FAIL ovr_no_req: got %0b want 0", ifc.fk_req); end
    tick();
    n_chk++; if (ifc.fk_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_width: got %0b want 0", ifc.fk_ovr); end
    k = 0;
    while (ifc.pll_ready !== 1'b1 && k < 800) begin tick(); k++; end
    n_chk++; if (cyc - t_load != 721) begin n_fail++; $display("FAIL ovr_seq_cont: ready at load+%0d want load+721", cyc - t_load); end
    n_chk++; if (ifc.pll_chan !== 7'd20) begin n_fail++; $display("FAIL ovr_chan: got %0d want 20", ifc.pll_chan); end
  endtask

  task automatic test_disable();
    resync();
    wait_fkset(100);
    tick();
    ifc.fk_ack = 1'b1; ifc.fk_chan = 7'd50;
    tick();
    ifc.fk_ack = 1'b0;
    ticks(3);
    ifc.hop_en = 1'b0;
    tick();
    n_chk++; if ({ifc.fk_req, ifc.pll_load_p, ifc.pll_ready} !== 3'b000) begin n_fail++; $display("FAIL dis_outputs: req/load/ready got %03b want 000", {ifc.fk_req, ifc.pll_load_p, ifc.pll_ready}); end
    n_chk++; if (ifc.pll_chan !== 7'd50) begin n_fail++; $display("FAIL dis_chan_kept: got %0d want 50", ifc.pll_chan); end
    ifc.hop_en = 1'b1; ifc.pll_lock = 1'b1;
    ticks(2);
    ifc.pll_lock = 1'b0;
    n_chk++; if (ifc.pll_ready !== 1'b0) begin n_fail++; $display("FAIL dis_left_settle: got %0b want 0", ifc.pll_ready); end
    // ack arriving in the same cycle as disable must be dropped
    resync();
    wait_fkset(100);
    tick();
    ifc.hop_en = 1'b0; ifc.fk_ack = 1'b1; ifc.fk_chan = 7'd11;
    tick();
    ifc.fk_ack = 1'b0; ifc.hop_en = 1'b1;
    n_chk++; if (ifc.pll_load_p !== 1'b0 || ifc.fk_req !== 1'b0) begin n_fail++; $display("FAIL dis_ack_ignored: load=%0b req=%0b want 0 0", ifc.pll_load_p, ifc.fk_req); end
    n_chk++; if (ifc.pll_chan !== 7'd50) begin n_fail++; $display("FAIL dis_ack_chan: got %0d want 50", ifc.pll_chan); end
  endtask

  task automatic test_async_reset();
    resync();
    wait_fkset(100);
    tick();
    n_chk++; if (ifc.fk_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req: got %0b want 1", ifc.fk_req); end
    #2 rstz = 1'b0;
    #1;
    n_chk++; if (ifc.fk_req !== 1'b0) begin n_fail++; $display("FAIL async_rst_req: got %0b want 0", ifc.fk_req); end
    n_chk++; if (ifc.slot_cnt !== 12'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d want 0", ifc.slot_cnt); end
    n_chk++; if (ifc.pll_chan !== 7'd0) begin n_fail++; $display("FAIL async_rst_chan: got %0d want 0", ifc.pll_chan); end
    n_chk++; if ({ifc.fkset_p, ifc.pll_load_p, ifc.pll_ready, ifc.fk_err, ifc.fk_ovr} !== 5'b0) begin n_fail++; $display("FAIL async_rst_strobes: got %05b want 00000", {ifc.fkset_p, ifc.pll_load_p, ifc.pll_ready, ifc.fk_err, ifc.fk_ovr}); end
    #1 rstz = 1'b1;
    tick();
    wait_fkset(100);
    n_chk++; if (ifc.slot_cnt !== 12'd51) begin n_fail++; $display("FAIL restart_pos: got %0d want 51", ifc.slot_cnt); end
    tick();
    n_chk++; if (ifc.fk_req !== 1'b1) begin n_fail++; $display("FAIL restart_req: got %0b want 1", ifc.fk_req); end
    ifc.fk_ack = 1'b1; ifc.fk_chan = 7'd5;
    tick();
    ifc.fk_ack = 1'b0;
    n_chk++; if (ifc.pll_load_p !== 1'b1 || ifc.pll_chan !== 7'd5) begin n_fail++; $display("FAIL restart_load: load=%0b chan=%0d want 1 5", ifc.pll_load_p, ifc.pll_chan); end
  endtask

  initial begin
    test_reset();
    test_lead();
    test_nominal();
    test_bad_chan();
    test_ack_timeout();
    test_settle_timeout();
    test_overrun();
    test_disable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
